// File: rtl/microsequencer_if.sv
// microsequencer_if: status, decode, control-store load and microword output bundle.
interface microsequencer_if #(
    parameter int DATAWIDTH_DIRECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_CONDITION = 3,
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_DECODEROP = 8
);
    localparam int W = 5 + 3*DATAWIDTH_DIRECTION + DATAWIDTH_ALU_SELECTION + DATAWIDTH_CONDITION + DATAWIDTH_JUMPADDRESS;
    logic [3:0] MICROSEQUENCER_Flags_InBus;
    logic MICROSEQUENCER_IR13_In;
    logic [DATAWIDTH_DECODEROP-1:0] MICROSEQUENCER_Opcode_InBus;
    logic MICROSEQUENCER_MemReady_In;
    logic MICROSEQUENCER_LoadEnable_In;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_LoadAddress_InBus;
    logic [W-1:0] MICROSEQUENCER_LoadWord_InBus;
    logic MICROSEQUENCER_SelectA_Out;
    logic MICROSEQUENCER_SelectB_Out;
    logic MICROSEQUENCER_SelectC_Out;
    logic [DATAWIDTH_DIRECTION-1:0] MICROSEQUENCER_DirA_OutBus;
    logic [DATAWIDTH_DIRECTION-1:0] MICROSEQUENCER_DirB_OutBus;
    logic [DATAWIDTH_DIRECTION-1:0] MICROSEQUENCER_DirC_OutBus;
    logic MICROSEQUENCER_RD_Out;
    logic MICROSEQUENCER_WRMain_Out;
    logic [DATAWIDTH_ALU_SELECTION-1:0] MICROSEQUENCER_ALUOperation_OutBus;
    logic [DATAWIDTH_CONDITION-1:0] MICROSEQUENCER_Condition_OutBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_JumpAddress_OutBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_CSAddress_OutBus;
    logic MICROSEQUENCER_Stall_Out;
    modport slave (
        input MICROSEQUENCER_Flags_InBus, MICROSEQUENCER_IR13_In, MICROSEQUENCER_Opcode_InBus,
              MICROSEQUENCER_MemReady_In, MICROSEQUENCER_LoadEnable_In,
              MICROSEQUENCER_LoadAddress_InBus, MICROSEQUENCER_LoadWord_InBus,
        output MICROSEQUENCER_SelectA_Out, MICROSEQUENCER_SelectB_Out, MICROSEQUENCER_SelectC_Out,
               MICROSEQUENCER_DirA_OutBus, MICROSEQUENCER_DirB_OutBus, MICROSEQUENCER_DirC_OutBus,
               MICROSEQUENCER_RD_Out, MICROSEQUENCER_WRMain_Out, MICROSEQUENCER_ALUOperation_OutBus,
               MICROSEQUENCER_Condition_OutBus, MICROSEQUENCER_JumpAddress_OutBus,
               MICROSEQUENCER_CSAddress_OutBus, MICROSEQUENCER_Stall_Out
    );
    modport master (
        output MICROSEQUENCER_Flags_InBus, MICROSEQUENCER_IR13_In, MICROSEQUENCER_Opcode_InBus,
               MICROSEQUENCER_MemReady_In, MICROSEQUENCER_LoadEnable_In,
               MICROSEQUENCER_LoadAddress_InBus, MICROSEQUENCER_LoadWord_InBus,
        input MICROSEQUENCER_SelectA_Out, MICROSEQUENCER_SelectB_Out, MICROSEQUENCER_SelectC_Out,
              MICROSEQUENCER_DirA_OutBus, MICROSEQUENCER_DirB_OutBus, MICROSEQUENCER_DirC_OutBus,
              MICROSEQUENCER_RD_Out, MICROSEQUENCER_WRMain_Out, MICROSEQUENCER_ALUOperation_OutBus,
              MICROSEQUENCER_Condition_OutBus, MICROSEQUENCER_JumpAddress_OutBus,
              MICROSEQUENCER_CSAddress_OutBus, MICROSEQUENCER_Stall_Out
    );
endinterface

// File: rtl/microsequencer.sv
// microsequencer: loadable control store with CSAR/MIR, condition branching, decode dispatch and memory stall.
module microsequencer #(
    parameter int DATAWIDTH_DIRECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_CONDITION = 3,
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_DECODEROP = 8
) (
    input logic MICROSEQUENCER_CLOCK_50,
    input logic MICROSEQUENCER_ResetInLow_In,
    microsequencer_if.slave bus
);
    localparam int W = 5 + 3*DATAWIDTH_DIRECTION + DATAWIDTH_ALU_SELECTION + DATAWIDTH_CONDITION + DATAWIDTH_JUMPADDRESS;
    localparam int DEPTH = 2**DATAWIDTH_JUMPADDRESS;
    typedef struct packed {
        logic selectA;
        logic [DATAWIDTH_DIRECTION-1:0] dirA;
        logic selectB;
        logic [DATAWIDTH_DIRECTION-1:0] dirB;
        logic selectC;
        logic [DATAWIDTH_DIRECTION-1:0] dirC;
        logic rd;
        logic wrMain;
        logic [DATAWIDTH_ALU_SELECTION-1:0] aluOperation;
        logic [DATAWIDTH_CONDITION-1:0] condition;
        logic [DATAWIDTH_JUMPADDRESS-1:0] jumpAddress;
    } microWord_t;
    typedef enum logic [1:0] {BOOT, RUN, STALL, LOAD} state_t;
    state_t state, nextState, resumeState, nextResume;
    microWord_t mir;
    logic [DATAWIDTH_JUMPADDRESS-1:0] csar, nextAddress, fetchAddress;
    logic [W-1:0] store [DEPTH] = '{default: '0};
    logic [7:0] condTrue;
    logic memBusy, fetch;
    // Bit k is the branch-taken test for condition k; 7 (decode) is handled separately.
    assign condTrue = {1'b0, 1'b1, bus.MICROSEQUENCER_IR13_In, bus.MICROSEQUENCER_Flags_InBus[0],
                       bus.MICROSEQUENCER_Flags_InBus[1], bus.MICROSEQUENCER_Flags_InBus[2],
                       bus.MICROSEQUENCER_Flags_InBus[3], 1'b0};
    assign nextAddress = mir.condition == DATAWIDTH_CONDITION'(7) ? {1'b1, bus.MICROSEQUENCER_Opcode_InBus, 2'b00}
                       : condTrue[mir.condition] ? mir.jumpAddress
                       : csar + DATAWIDTH_JUMPADDRESS'(1);
    assign memBusy = (mir.rd | mir.wrMain) & ~bus.MICROSEQUENCER_MemReady_In;
    assign fetchAddress = state == BOOT ? '0 : nextAddress;
    always_comb begin
        nextState = state;
        nextResume = resumeState;
        fetch = 1'b0;
        if (bus.MICROSEQUENCER_LoadEnable_In) begin
            nextState = LOAD;
            nextResume = state == LOAD ? resumeState : state;
        end else begin
            unique case (state)
                BOOT: begin
                    nextState = RUN;
                    fetch = 1'b1;
                end
                RUN: begin
                    nextState = memBusy ? STALL : RUN;
                    fetch = ~memBusy;
                end
                STALL: begin
                    nextState = bus.MICROSEQUENCER_MemReady_In ? RUN : STALL;
                    fetch = bus.MICROSEQUENCER_MemReady_In;
                end
                LOAD: nextState = resumeState;
            endcase
        end
    end
    always_ff @(posedge MICROSEQUENCER_CLOCK_50 or negedge MICROSEQUENCER_ResetInLow_In) begin
        if (!MICROSEQUENCER_ResetInLow_In) begin
            state <= BOOT;
            resumeState <= RUN;
            csar <= '0;
            mir <= '0;
        end else begin
            state <= nextState;
            resumeState <= nextResume;
            if (fetch) begin
                csar <= fetchAddress;
                mir <= microWord_t'(store[fetchAddress]);
            end
        end
    end
    // Store is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge MICROSEQUENCER_CLOCK_50) begin
        if (bus.MICROSEQUENCER_LoadEnable_In) store[bus.MICROSEQUENCER_LoadAddress_InBus] <= bus.MICROSEQUENCER_LoadWord_InBus;
    end
    assign bus.MICROSEQUENCER_SelectA_Out = mir.selectA;
    assign bus.MICROSEQUENCER_DirA_OutBus = mir.dirA;
    assign bus.MICROSEQUENCER_SelectB_Out = mir.selectB;
    assign bus.MICROSEQUENCER_DirB_OutBus = mir.dirB;
    assign bus.MICROSEQUENCER_SelectC_Out = mir.selectC;
    assign bus.MICROSEQUENCER_DirC_OutBus = mir.dirC;
    assign bus.MICROSEQUENCER_RD_Out = mir.rd;
    assign bus.MICROSEQUENCER_WRMain_Out = mir.wrMain;
    assign bus.MICROSEQUENCER_ALUOperation_OutBus = mir.aluOperation;
    assign bus.MICROSEQUENCER_Condition_OutBus = mir.condition;
    assign bus.MICROSEQUENCER_JumpAddress_OutBus = mir.jumpAddress;
    assign bus.MICROSEQUENCER_CSAddress_OutBus = csar;
    assign bus.MICROSEQUENCER_Stall_Out = state != RUN;
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: scoreboard bench walking branch, decode, stall, load and reset scenarios.
module tb_microsequencer;
    localparam int D = 6, A = 4, C = 3, J = 11, O = 8;
    localparam int W = 5 + 3*D + A + C + J;
    typedef struct {
        string tag;
        logic [J-1:0] csar;
        logic [W-1:0] word;
        logic stall;
    } expect_t;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic [W-1:0] tbStore [2**J] = '{default: '0};
    logic [W-1:0] obsWord;
    expect_t expQ[$];
    int checks = 0;
    int passes = 0;
    microsequencer_if #(D, A, C, J, O) bus();
    microsequencer #(
        .DATAWIDTH_DIRECTION(D), .DATAWIDTH_ALU_SELECTION(A), .DATAWIDTH_CONDITION(C),
        .DATAWIDTH_JUMPADDRESS(J), .DATAWIDTH_DECODEROP(O)
    ) dut (
        .MICROSEQUENCER_CLOCK_50(clk),
        .MICROSEQUENCER_ResetInLow_In(rstN),
        .bus(bus)
    );
    always #5 clk = ~clk;
    assign obsWord = {bus.MICROSEQUENCER_SelectA_Out, bus.MICROSEQUENCER_DirA_OutBus,
                      bus.MICROSEQUENCER_SelectB_Out, bus.MICROSEQUENCER_DirB_OutBus,
                      bus.MICROSEQUENCER_SelectC_Out, bus.MICROSEQUENCER_DirC_OutBus,
                      bus.MICROSEQUENCER_RD_Out, bus.MICROSEQUENCER_WRMain_Out,
                      bus.MICROSEQUENCER_ALUOperation_OutBus, bus.MICROSEQUENCER_Condition_OutBus,
                      bus.MICROSEQUENCER_JumpAddress_OutBus};
    function automatic logic [W-1:0] mk(input logic rd, input logic [A-1:0] alu, input logic [C-1:0] cond,
                                        input logic [J-1:0] jump, input logic [D-1:0] dir);
        return {1'b1, dir, 1'b0, dir + D'(1), 1'b1, dir + D'(2), rd, 1'b0, alu, cond, jump};
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic compareNow();
        expect_t e;
        e = expQ.pop_front();
        check({e.tag, ".csar"}, 64'(bus.MICROSEQUENCER_CSAddress_OutBus), 64'(e.csar));
        check({e.tag, ".word"}, 64'(obsWord), 64'(e.word));
        check({e.tag, ".stall"}, 64'(bus.MICROSEQUENCER_Stall_Out), 64'(e.stall));
    endtask
    task automatic step(input string tag, input logic [J-1:0] csar, input logic stall);
        expQ.push_back('{tag, csar, tbStore[csar], stall});
        @(posedge clk);
        #1;
        compareNow();
    endtask
    task automatic load(input logic [J-1:0] addr, input logic [W-1:0] word);
        bus.MICROSEQUENCER_LoadEnable_In = 1'b1;
        bus.MICROSEQUENCER_LoadAddress_InBus = addr;
        bus.MICROSEQUENCER_LoadWord_InBus = word;
        tbStore[addr] = word;
        @(posedge clk);
        #1;
        bus.MICROSEQUENCER_LoadEnable_In = 1'b0;
    endtask
    initial begin
        bus.MICROSEQUENCER_Flags_InBus = 4'b0000;
        bus.MICROSEQUENCER_IR13_In = 1'b0;
        bus.MICROSEQUENCER_Opcode_InBus = 8'h95;
        bus.MICROSEQUENCER_MemReady_In = 1'b0;
        bus.MICROSEQUENCER_LoadEnable_In = 1'b0;
        bus.MICROSEQUENCER_LoadAddress_InBus = '0;
        bus.MICROSEQUENCER_LoadWord_InBus = '0;
        #2;
        expQ.push_back('{"reset", '0, '0, 1'b1});
        compareNow();
        load(11'h000, mk(1'b0, 4'h3, 3'b000, 11'h000, 6'h05));
        load(11'h001, mk(1'b0, 4'h1, 3'b110, 11'h005, 6'h0A));
        load(11'h005, mk(1'b0, 4'h2, 3'b110, 11'h020, 6'h11));
        load(11'h020, mk(1'b0, 4'h4, 3'b010, 11'h100, 6'h17));
        load(11'h100, mk(1'b0, 4'h5, 3'b110, 11'h020, 6'h1C));
        load(11'h021, mk(1'b0, 4'h6, 3'b111, 11'h3FF, 6'h22));
        load(11'h654, mk(1'b1, 4'h7, 3'b110, 11'h7FF, 6'h2A));
        load(11'h7FF, mk(1'b0, 4'h8, 3'b000, 11'h123, 6'h33));
        rstN = 1'b1;
        expQ.push_back('{"boot", '0, '0, 1'b1});
        compareNow();
        step("w0", 11'h000, 1'b0);
        step("w1", 11'h001, 1'b0);
        step("jump5", 11'h005, 1'b0);
        step("cond010", 11'h020, 1'b0);
        bus.MICROSEQUENCER_Flags_InBus = 4'b0100;
        step("zTaken", 11'h100, 1'b0);
        step("back", 11'h020, 1'b0);
        bus.MICROSEQUENCER_Flags_InBus = 4'b1011;
        step("zNotTaken", 11'h021, 1'b0);
        step("decode", 11'h654, 1'b0);
        for (int i = 0; i < 3; i++) step("memStall", 11'h654, 1'b1);
        bus.MICROSEQUENCER_MemReady_In = 1'b1;
        step("memDone", 11'h7FF, 1'b0);
        bus.MICROSEQUENCER_MemReady_In = 1'b0;
        step("wrap", 11'h000, 1'b0);
        step("w1b", 11'h001, 1'b0);
        step("jump5b", 11'h005, 1'b0);
        step("cond010b", 11'h020, 1'b0);
        step("zNotTakenB", 11'h021, 1'b0);
        step("decodeB", 11'h654, 1'b0);
        step("stallB", 11'h654, 1'b1);
        bus.MICROSEQUENCER_LoadEnable_In = 1'b1;
        bus.MICROSEQUENCER_LoadAddress_InBus = 11'h000;
        bus.MICROSEQUENCER_LoadWord_InBus = mk(1'b0, 4'h9, 3'b110, 11'h040, 6'h3C);
        tbStore[0] = bus.MICROSEQUENCER_LoadWord_InBus;
        step("load", 11'h654, 1'b1);
        step("loadHold", 11'h654, 1'b1);
        bus.MICROSEQUENCER_LoadEnable_In = 1'b0;
        step("resumeStall", 11'h654, 1'b1);
        bus.MICROSEQUENCER_LoadEnable_In = 1'b1;
        step("reload", 11'h654, 1'b1);
        rstN = 1'b0;
        #1;
        expQ.push_back('{"midReset", '0, '0, 1'b1});
        compareNow();
        bus.MICROSEQUENCER_LoadEnable_In = 1'b0;
        #1;
        rstN = 1'b1;
        step("refetch0", 11'h000, 1'b0);
        step("afterNew", 11'h040, 1'b0);
        step("afterNewInc", 11'h041, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
